// File: rtl/mult_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_ctrl
// Description : Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU)
//               using shift-add multiply and restoring shift-subtract divide.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_count;
  logic [1:0]         r_op;
  logic               r_negQ;
  logic               r_negR;
  logic [WIDTH-1:0]   r_factor;
  logic [WIDTH-1:0]   r_workHi;
  logic [WIDTH-1:0]   r_workLo;

  logic               w_isSigned;
  logic               w_divByZero;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quotFix;
  logic [WIDTH-1:0]   w_remFix;

  // Signed ops work on magnitudes; the most negative value maps onto itself,
  // which is still the correct unsigned magnitude.
  assign w_isSigned  = ~op[0];
  assign w_divByZero = op[1] && (opB == '0);
  assign w_absA      = (w_isSigned && opA[WIDTH-1]) ? -opA : opA;
  assign w_absB      = (w_isSigned && opB[WIDTH-1]) ? -opB : opB;

  assign w_mulSum  = {1'b0, r_workHi} + (r_workLo[0] ? {1'b0, r_factor} : '0);
  assign w_shifted = {r_workHi, r_workLo[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, r_factor};

  assign w_prod    = {r_workHi, r_workLo};
  assign w_prodFix = r_negQ ? -w_prod : w_prod;
  assign w_quotFix = r_negQ ? -r_workLo : r_workLo;
  assign w_remFix  = r_negR ? -r_workHi : r_workHi;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = w_divByZero ? DONE : ITER;
        end
      end
      ITER: begin
        busy = 1'b1;
        if (r_count == CNT_W'(1)) begin
          w_nextState = FIX;
        end
      end
      FIX: begin
        busy        = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_op     <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_factor <= '0;
      r_workHi <= '0;
      r_workLo <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op     <= op;
            r_count  <= CNT_W'(WIDTH);
            r_negQ   <= w_isSigned & (opA[WIDTH-1] ^ opB[WIDTH-1]);
            r_negR   <= w_isSigned & op[1] & opA[WIDTH-1];
            r_workHi <= '0;
            div_zero <= w_divByZero;
            // Divide shifts the dividend out of workLo; multiply shifts the multiplier.
            if (op[1]) begin
              r_factor <= w_absB;
              r_workLo <= w_absA;
            end else begin
              r_factor <= w_absA;
              r_workLo <= w_absB;
            end
          end
        end
        ITER: begin
          r_count <= r_count - CNT_W'(1);
          if (r_op[1]) begin
            if (!w_diff[WIDTH]) begin
              r_workHi <= w_diff[WIDTH-1:0];
              r_workLo <= {r_workLo[WIDTH-2:0], 1'b1};
            end else begin
              r_workHi <= w_shifted[WIDTH-1:0];
              r_workLo <= {r_workLo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {r_workHi, r_workLo} <= {w_mulSum, r_workLo[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (r_op[1]) begin
            hi <= w_remFix;
            lo <= w_quotFix;
          end else begin
            {hi, lo} <= w_prodFix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_ctrl
// Description : Directed-vector bench for mult_div_ctrl (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          pulse;
    logic [31:0] expHi;
    logic [31:0] expLo;
    bit          expDz;
  } vec_t;

  vec_t vecs[14];

  mult_div_ctrl #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .opA      (opA),
    .opB      (opB),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic doOp(input string name, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input bit pulse, input logic [31:0] eh,
                      input logic [31:0] el, input bit edz);
    int expDone;
    int busyBad;
    int doneCnt;
    int doneAt;
    expDone = (o[1] && b == 32'd0) ? 1 : 34;
    busyBad = 0;
    doneCnt = 0;
    doneAt  = -1;
    op = o; opA = a; opB = b; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    opA = $urandom;
    opB = $urandom;
    op  = 2'($urandom_range(0, 3));
    for (int c = 1; c <= expDone + 2; c++) begin
      @(negedge clock);
      if (busy !== (c < expDone)) busyBad++;
      if (done === 1'b1) begin
        doneCnt++;
        doneAt = c;
      end
      if (c == expDone) begin
        check({name, ".hi"}, 64'(hi), 64'(eh));
        check({name, ".lo"}, 64'(lo), 64'(el));
        check({name, ".div_zero"}, 64'(div_zero), 64'(edz));
      end
      start = pulse && (c < expDone);
    end
    start = 1'b0;
    check({name, ".done_cycle"}, 64'(doneAt), 64'(expDone));
    check({name, ".done_count"}, 64'(doneCnt), 64'd1);
    check({name, ".busy_pattern_errors"}, 64'(busyBad), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{"mult_7_m3",     MULT,  32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{"multu_max",     MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{"div_m7_2",      DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{"divu_100_7",    DIVU,  32'd100,       32'd7,         1'b0, 32'd2,         32'd14,        1'b0};
    vecs[4]  = '{"divu_by_zero",  DIVU,  32'd100,       32'd0,         1'b0, 32'd2,         32'd14,        1'b1};
    vecs[5]  = '{"mult_5_6",      MULT,  32'd5,         32'd6,         1'b0, 32'd0,         32'd30,        1'b0};
    vecs[6]  = '{"div_overflow",  DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[7]  = '{"multu_by_zero", MULTU, 32'h1234_5678, 32'd0,         1'b0, 32'd0,         32'd0,         1'b0};
    vecs[8]  = '{"div_7_m2",      DIV,   32'd7,         32'hFFFF_FFFE, 1'b0, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{"mult_minsq",    MULT,  32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{"divu_max_1",    DIVU,  32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{"div_m100_m7",   DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFFE, 32'd14,        1'b0};
    vecs[12] = '{"multu_2p32",    MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd1,         32'd0,         1'b0};
    vecs[13] = '{"div_6_3",       DIV,   32'd6,         32'd3,         1'b0, 32'd0,         32'd2,         1'b0};

    reset = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
    repeat (2) @(negedge clock);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.lo", 64'(lo), 64'd0);
    check("reset.div_zero", 64'(div_zero), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 14; i++) begin
      doOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pulse,
           vecs[i].expHi, vecs[i].expLo, vecs[i].expDz);
    end

    // Abandon a MULTU in its 10th ITER cycle with an asynchronous reset.
    op = MULTU; opA = 32'hFFFF_FFFF; opB = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clock);
    check("midop.busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midop.busy", 64'(busy), 64'd0);
    check("midop.done", 64'(done), 64'd0);
    check("midop.hi", 64'(hi), 64'd0);
    check("midop.lo", 64'(lo), 64'd0);
    @(negedge clock);
    check("midop.hi_held_in_reset", 64'(hi), 64'd0);
    reset = 1'b0;
    doOp("post_reset_multu", MULTU, 32'd3, 32'd5, 1'b0, 32'd0, 32'd15, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
